// File: rtl/nanov_pkg.sv
// Shared definitions for the nanoV output peripheral: select byte, bit-op encodings,
// scan state encoding and the small datapath helpers used by the register bank.
package nanov_pkg;

    localparam logic [7:0] BASE_ADDR_HI = 8'h10;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_SET    = 2'b01,
        OP_CLR    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // The CPU shifts store data out LSB-last, so the received word arrives mirrored.
    function automatic logic [31:0] bitrev32(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = d[31-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] apply_op(input op_e op, input logic [31:0] cur,
                                             input logic [31:0] d);
        logic [31:0] r;
        case (op)
            OP_WRITE:  r = d;
            OP_SET:    r = cur | d;
            OP_CLR:    r = cur & ~d;
            OP_TOGGLE: r = cur ^ d;
            default:   r = cur;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/nanov_led_mux.sv
// Column-multiplexed LED scanner: alternates dark gaps and lit columns, showing one
// frame snapshot of the source word per full sweep so a frame never tears.
module nanov_led_mux
    import nanov_pkg::*;
#(
    parameter int NUM_COLS = 4,
    parameter int ROW_W    = 8,
    parameter int DWELL    = 4096,
    parameter int BLANK    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         frame,
    output logic [ROW_W-1:0]    leds,
    output logic [NUM_COLS-1:0] lcol
);

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(NUM_COLS - 1);

    scan_state_e         r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [COL_W-1:0]    r_col;
    logic [31:0]         r_snap;
    logic [ROW_W-1:0]    r_leds;
    logic [NUM_COLS-1:0] r_lcol;

    logic [31:0]         w_src;

    // Column 0 starts a new frame, so it must display the word being snapshotted now.
    assign w_src = (r_col == '0) ? frame : r_snap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_col   <= '0;
            r_snap  <= '0;
            r_leds  <= '0;
            r_lcol  <= '0;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == BLANK_END) begin
                        r_state <= ST_SHOW;
                        r_cnt   <= '0;
                        r_lcol  <= NUM_COLS'(1) << r_col;
                        r_leds  <= w_src[ROW_W*r_col +: ROW_W];
                        if (r_col == '0) begin
                            r_snap <= frame;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == DWELL_END) begin
                        r_state <= ST_BLANK;
                        r_cnt   <= '0;
                        r_lcol  <= '0;
                        r_leds  <= '0;
                        r_col   <= (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_BLANK;
            endcase
        end
    end

    assign leds = r_leds;
    assign lcol = r_lcol;

endmodule

// File: rtl/nanov_periph_out.sv
// nanoV memory-mapped output peripheral: address decode, register bank with
// write/set/clear/toggle access, write strobes, and LED matrix driven from register 0.
module nanov_periph_out
    import nanov_pkg::*;
#(
    parameter logic [7:0] BASE_HI  = BASE_ADDR_HI,
    parameter int         NUM_REGS = 4,
    parameter int         REVERSE  = 1,
    parameter int         NUM_COLS = 4,
    parameter int         ROW_W    = 8,
    parameter int         DWELL    = 4096,
    parameter int         BLANK    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     latch_addr,
    input  logic                     latch_data,
    input  logic [31:0]              raw_data,
    output logic [32*NUM_REGS-1:0]   regs,
    output logic [NUM_REGS-1:0]      wr_pulse,
    output logic [ROW_W-1:0]         leds,
    output logic [NUM_COLS-1:0]      lcol
);

    logic                r_sel;
    logic [7:0]          r_addr;
    logic [31:0]         r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_pulse;

    logic [5:0]          w_idx;
    op_e                 w_op;
    logic [31:0]         w_data;
    logic                w_write;

    assign w_idx   = r_addr[7:2];
    assign w_op    = op_e'(r_addr[1:0]);
    assign w_data  = (REVERSE != 0) ? bitrev32(raw_data) : raw_data;
    assign w_write = latch_data & r_sel;

    // Data phase reads the sel/addr registered earlier, so a same-cycle address only
    // affects later stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel  <= 1'b0;
            r_addr <= '0;
        end else if (latch_addr) begin
            if (raw_data[31:24] == BASE_HI) begin
                r_sel  <= 1'b1;
                r_addr <= raw_data[7:0];
            end else begin
                r_sel  <= 1'b0;
            end
        end
    end

    // Indices at or above NUM_REGS match no bank entry and are silently dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_pulse <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_write && (w_idx == 6'(i))) begin
                    r_regs[i]     <= apply_op(w_op, r_regs[i], w_data);
                    r_wr_pulse[i] <= 1'b1;
                end else begin
                    r_wr_pulse[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        regs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[32*i +: 32] = r_regs[i];
        end
    end

    assign wr_pulse = r_wr_pulse;

    nanov_led_mux #(
        .NUM_COLS (NUM_COLS),
        .ROW_W    (ROW_W),
        .DWELL    (DWELL),
        .BLANK    (BLANK)
    ) u_led_mux (
        .clk   (clk),
        .rst   (rst),
        .frame (r_regs[0]),
        .leds  (leds),
        .lcol  (lcol)
    );

endmodule

// File: tb/tb_nanov_periph_out.sv
// Scoreboard bench for nanov_periph_out: register accesses, decode misses, strobes,
// LED scan timing with frame snapshots, and asynchronous reset behaviour.
module tb_nanov_periph_out;

    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              latch_addr = 1'b0;
    logic              latch_data = 1'b0;
    logic [31:0]       raw_data = '0;
    logic [32*NR-1:0]  regs;
    logic [NR-1:0]     wr_pulse;
    logic [7:0]        leds;
    logic [3:0]        lcol;

    nanov_periph_out #(
        .BASE_HI  (8'h10),
        .NUM_REGS (NR),
        .REVERSE  (1),
        .NUM_COLS (4),
        .ROW_W    (8),
        .DWELL    (4),
        .BLANK    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .latch_addr (latch_addr),
        .latch_data (latch_data),
        .raw_data   (raw_data),
        .regs       (regs),
        .wr_pulse   (wr_pulse),
        .leds       (leds),
        .lcol       (lcol)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_regs [NR];
    logic        m_sel;
    logic [7:0]  m_addr;

    function automatic logic [31:0] rev(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31-i] = d[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_sel  = 1'b0;
        m_addr = '0;
        sb.delete();
    endtask

    // One bus cycle: drive at negedge, advance the reference model with pre-edge state.
    task automatic cycle(input logic la, input logic ld, input logic [31:0] d);
        int          idx;
        logic [31:0] v;
        logic [31:0] nv;
        @(negedge clk);
        latch_addr = la;
        latch_data = ld;
        raw_data   = d;
        if (ld && m_sel && (int'(m_addr[7:2]) < NR)) begin
            idx = int'(m_addr[7:2]);
            v   = rev(d);
            case (m_addr[1:0])
                2'b00:   nv = v;
                2'b01:   nv = m_regs[idx] | v;
                2'b10:   nv = m_regs[idx] & ~v;
                default: nv = m_regs[idx] ^ v;
            endcase
            m_regs[idx] = nv;
            sb.push_back('{idx, nv});
        end
        if (la) begin
            if (d[31:24] == 8'h10) begin
                m_sel  = 1'b1;
                m_addr = d[7:0];
            end else begin
                m_sel = 1'b0;
            end
        end
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
        cycle(1'b1, 1'b0, addr);
        cycle(1'b0, 1'b1, data);
        cycle(1'b0, 1'b0, 32'h0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            check($sformatf("%s_reg%0d", tag, i), regs[32*i +: 32], m_regs[i]);
        check($sformatf("%s_sb_drained", tag), sb.size(), 0);
    endtask

    // Strobe monitor: every wr_pulse must match the oldest expected register update.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (!rst && wr_pulse !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(wr_pulse), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_bits", 32'(wr_pulse), 32'(1) << mon_e.idx);
                check("pulse_value", regs[32*mon_e.idx +: 32], mon_e.val);
            end
        end
    end

    logic [31:0] exp_frame;
    logic [31:0] last0;
    logic [31:0] exp_l;
    logic [31:0] exp_d;
    int          wait_cnt;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_reg0", regs[31:0], 32'h0);
        check("rst_reg3", regs[127:96], 32'h0);
        check("rst_pulse", 32'(wr_pulse), 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_lcol", 32'(lcol), 32'h0);
        rst = 1'b0;

        // Scan timing with DWELL=4, BLANK=2: first column lights on the 2nd edge.
        exp_frame = '0;
        last0     = '0;
        fork
            begin
                for (int k = 1; k <= 80; k++) begin
                    @(posedge clk);
                    #1;
                    exp_l = '0;
                    exp_d = '0;
                    if (k >= 2) begin
                        if ((k - 2) % 24 == 0) exp_frame = last0;
                        if ((k - 2) % 6 < 4) begin
                            exp_l = 32'(1) << (((k - 2) / 6) % 4);
                            exp_d = (exp_frame >> (8 * (((k - 2) / 6) % 4))) & 32'hFF;
                        end
                    end
                    check($sformatf("scan_lcol_k%0d", k), 32'(lcol), exp_l);
                    check($sformatf("scan_leds_k%0d", k), 32'(leds), exp_d);
                    last0 = m_regs[0];
                end
            end
            begin
                cpu_write(32'h1000_0000, rev(32'hAABB_CCDD));
                repeat (25) @(negedge clk);
                cpu_write(32'h1000_0000, rev(32'h1122_3344));
            end
        join
        check_regs("scan");
        check("scan_reg0_final", regs[31:0], 32'h1122_3344);

        cpu_write(32'h1000_0000, 32'h0000_0001);
        check("write_reg0", regs[31:0], 32'h8000_0000);
        check_regs("write");

        cpu_write(32'h1000_0004, rev(32'hF000_0000));
        cpu_write(32'h1000_0008, 32'hFFFF_FFFF);
        cpu_write(32'h1000_0005, rev(32'h0000_000F));
        check("set_reg1", regs[63:32], 32'hF000_000F);
        cpu_write(32'h1000_000A, rev(32'h0000_FF00));
        check("clr_reg2", regs[95:64], 32'hFFFF_00FF);
        cpu_write(32'h1000_000F, rev(32'h0000_00FF));
        check("tog_reg3", regs[127:96], 32'h0000_00FF);
        cpu_write(32'h1000_000F, 32'hFFFF_FFFF);
        check("tog2_reg3", regs[127:96], 32'hFFFF_FF00);
        check_regs("ops");

        cpu_write(32'h2000_0000, 32'hFFFF_FFFF);
        check_regs("foreign_base");
        cpu_write(32'h1000_00FC, 32'hFFFF_FFFF);
        check_regs("idx_out_of_range");

        cycle(1'b1, 1'b0, 32'h1000_0008);
        cycle(1'b1, 1'b1, 32'h1000_0004);
        cycle(1'b0, 1'b1, rev(32'h0000_0100));
        cycle(1'b0, 1'b0, 32'h0);
        check("simul_reg2", regs[95:64], 32'h2000_0008);
        check("simul_reg1", regs[63:32], 32'h0000_0100);
        check_regs("simul");

        cycle(1'b1, 1'b0, 32'h1000_0005);
        cycle(1'b0, 1'b1, rev(32'h0000_0001));
        cycle(1'b0, 1'b1, rev(32'h0000_0002));
        cycle(1'b0, 1'b0, 32'h0);
        check("b2b_reg1", regs[63:32], 32'h0000_0103);
        check_regs("b2b");

        wait_cnt = 0;
        while (lcol == '0 && wait_cnt < 40) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        check("show_reached", 32'(lcol != '0), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midrst_lcol", 32'(lcol), 32'h0);
        check("midrst_leds", 32'(leds), 32'h0);
        for (int i = 0; i < NR; i++)
            check($sformatf("midrst_reg%0d", i), regs[32*i +: 32], 32'h0);
        check("midrst_pulse", 32'(wr_pulse), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        cycle(1'b1, 1'b0, 32'h1000_0000);
        @(negedge clk);
        latch_addr = 1'b0;
        latch_data = 1'b1;
        raw_data   = 32'hFFFF_FFFF;
        rst        = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        latch_data = 1'b0;
        model_reset();
        check_regs("abort");
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b0, 32'h0);
        check_regs("abort_nosel");

        check("sb_final", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
